spectrum_acc_writer: RTL and testbench
======================================

SPECTRUM_ACC_WRITER -- requirements
Module: spectrum_acc_writer

Interface
REQ-001 The parameters SHALL be: TOTAL_RANGEBIN, 9, number of range bins per pulse; RANGE_IN_POINTS, 1024, points per range bin; PD_CYCLES, 9240, length of the peak-detection enable window in clk cycles.
REQ-002 The ports SHALL be as follows; reset is rst, asynchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- acc_start  in  1  one-cycle pulse that starts a frame
- acc_pulses  in  16  pulses per frame, sampled on acc_start
- din_valid  in  1  input sample qualifier
- din_sop  in  1  first sample of a pulse, qualified by din_valid
- din  in  32  unsigned power sample
- rd_addr  out  14  buffer read address, {bin[3:0], point[9:0]}
- rd_data  in  32  buffer read data, 1-cycle latency
- wr_en  out  1  buffer write strobe
- wr_addr  out  14  buffer write address
- wr_data  out  32  buffer write data
- pd_en  out  1  level enable to the peak detector
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse at the end of the PD window
- err  out  1  sticky framing/overflow error

Function
REQ-003 The FSM SHALL have the states IDLE, ACCUM, FLUSH, PD_RUN and DONE.
REQ-004 IDLE->ACCUM SHALL occur on acc_start when acc_pulses != 0; acc_start with acc_pulses = 0 SHALL be ignored.
REQ-005 acc_start SHALL be ignored in any state other than IDLE.
REQ-006 On entry to ACCUM, pulse_cnt, bin and point SHALL all be cleared to 0.
REQ-007 In ACCUM, accepted samples SHALL be addressed {bin, point}; point SHALL increment per accepted sample and wrap from RANGE_IN_POINTS-1 to 0 while incrementing bin.
REQ-008 A pulse SHALL be complete when the sample at bin TOTAL_RANGEBIN-1, point RANGE_IN_POINTS-1 is accepted; pulse_cnt SHALL then increment and the address counters SHALL hold until the next din_sop.
REQ-009 Samples SHALL be accepted only from a din_sop sample up to pulse completion; any other din_valid sample SHALL be dropped and SHALL set err.
REQ-010 When din_sop arrives mid-pulse, err SHALL be set, the counters SHALL realign to {0,0}, that sample SHALL be accepted as point 0, and pulse_cnt SHALL not increment for the aborted pulse.
REQ-011 Read-modify-write: for an accepted sample at cycle t, rd_addr SHALL equal its address at t; at t+1, wr_en = 1, wr_addr = the same address, and wr_data = din if pulse_cnt = 0, else rd_data + din.
REQ-012 The add SHALL be 32-bit unsigned and saturating: a carry out SHALL produce 32'hFFFFFFFF and set err.
REQ-013 din SHALL be registered one cycle to align it with rd_data; there SHALL be no bypass, since successive accepted addresses differ.
REQ-014 When pulse_cnt reaches acc_pulses, the FSM SHALL go ACCUM->FLUSH; FLUSH SHALL last exactly 1 cycle so the final write completes, then go to PD_RUN.
REQ-015 PD_RUN SHALL hold pd_en = 1 for exactly PD_CYCLES cycles; in this state rd_addr SHALL be 0, wr_en SHALL be 0, and input samples SHALL be dropped without setting err.
REQ-016 DONE SHALL last 1 cycle with frame_done = 1, then return to IDLE.
REQ-017 In IDLE, wr_en SHALL be 0 and din_valid SHALL be ignored.
REQ-018 err SHALL clear on reset or on an accepted acc_start.

Reset
REQ-019 On rst assertion, the FSM SHALL go to IDLE immediately, including mid-frame.
REQ-020 Under rst, all counters SHALL be 0 and rd_addr, wr_en, wr_addr, wr_data, pd_en, busy, frame_done and err SHALL all be 0.
REQ-021 Buffer contents SHALL be undefined after a mid-frame reset, since the next frame overwrites them on pulse 0.

Structure
REQ-022 A shared package SHALL hold TOTAL_RANGEBIN, RANGE_IN_POINTS, the address widths (4+10) and the FSM state encoding, common with the peak detector.
REQ-023 One sub-module, sat_add32 (registered saturating adder with overflow flag), SHALL be instantiated for the write data path.

Verification
REQ-024 acc_pulses = 1, one full pulse with din = point index -> 9216 writes with wr_data = din at wr_addr = {bin, point}, then pd_en high for 9240 cycles, then frame_done.
REQ-025 acc_pulses = 3, din = 5 constant -> every address has final written value 15; wr_en is never asserted during PD_RUN.
REQ-026 Pulse 1 din = 32'hFFFFFFF0 and pulse 2 din = 32'h20 at address 0 -> wr_data = 32'hFFFFFFFF and err = 1.
REQ-027 din_sop at bin 2, point 100 of pulse 1 -> err = 1, next write address is 14'h0000, and pulse_cnt stays 0.
REQ-028 Second acc_start during ACCUM -> ignored, busy stays 1, and the frame completes normally.
REQ-029 rst asserted mid-ACCUM -> all outputs 0 in the same cycle; a new acc_start then runs a clean frame with err = 0.

Source files
------------

// File: rtl/spectrum_acc_writer_pkg.sv
// Shared constants and FSM encoding for the spectrum accumulator
// writer and the downstream peak detector.
package spectrum_acc_writer_pkg;

  localparam int TOTAL_RANGEBIN  = 9;
  localparam int RANGE_IN_POINTS = 1024;
  localparam int PD_CYCLES       = 9240;

  localparam int BIN_W  = 4;
  localparam int PT_W   = 10;
  localparam int ADDR_W = BIN_W + PT_W;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_PD_RUN,
    S_DONE
  } acc_state_e;

endpackage

// File: rtl/spectrum_acc_writer_sat_add32.sv
// Saturating accumulate stage: registers the new sample so it lines
// up with the 1-cycle buffer read, then adds with carry clamp.
module sat_add32
  import spectrum_acc_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic [DATA_W-1:0] in_din,
  input  logic [DATA_W-1:0] acc_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W:0]   raw;

  always_comb begin
    valid_d = in_valid;
    first_d = in_valid ? in_first : first_q;
    din_d   = in_valid ? in_din : din_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      din_q   <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    raw       = {1'b0, acc_in} + {1'b0, din_q};
    out_valid = valid_q;
    sum       = '0;
    ovf       = 1'b0;
    if (valid_q) begin
      if (first_q) begin
        sum = din_q;
      end else if (raw[DATA_W]) begin
        sum = '1;
        ovf = 1'b1;
      end else begin
        sum = raw[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spectrum_acc_writer.sv
// Accumulates power samples over N pulses into an external buffer,
// then opens the peak-detection window.
module spectrum_acc_writer
  import spectrum_acc_writer_pkg::*;
#(
  parameter int TOTAL_RANGEBIN  = spectrum_acc_writer_pkg::TOTAL_RANGEBIN,
  parameter int RANGE_IN_POINTS = spectrum_acc_writer_pkg::RANGE_IN_POINTS,
  parameter int PD_CYCLES       = spectrum_acc_writer_pkg::PD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_start,
  input  logic [15:0]       acc_pulses,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pd_en,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int PD_W = $clog2(PD_CYCLES + 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(TOTAL_RANGEBIN - 1);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(RANGE_IN_POINTS - 1);
  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);

  acc_state_e        state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [PT_W-1:0]   point_q, point_d;
  logic [15:0]       pulse_cnt_q, pulse_cnt_d;
  logic [15:0]       acc_pulses_q, acc_pulses_d;
  logic              in_pulse_q, in_pulse_d;
  logic              err_q, err_d;
  logic [PD_W-1:0]   pd_cnt_q, pd_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              start_ok, in_accum, accept;
  logic              drop_err, realign, pulse_end;
  logic [BIN_W-1:0]  cur_bin;
  logic [PT_W-1:0]   cur_point;
  logic [15:0]       pulse_cnt_inc;
  logic              ovf;

  always_comb begin
    start_ok  = (state_q == S_IDLE) && acc_start && (acc_pulses != '0);
    in_accum  = (state_q == S_ACCUM);
    accept    = in_accum && din_valid && (din_sop || in_pulse_q);
    drop_err  = in_accum && din_valid && !din_sop && !in_pulse_q;
    realign   = in_accum && din_valid && din_sop && in_pulse_q;
    cur_bin   = din_sop ? '0 : bin_q;
    cur_point = din_sop ? '0 : point_q;
    pulse_end = accept && (cur_bin == BIN_LAST) && (cur_point == PT_LAST);
    pulse_cnt_inc = pulse_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_ok) state_d = S_ACCUM;
      S_ACCUM:  if (pulse_end && (pulse_cnt_inc == acc_pulses_q))
                  state_d = S_FLUSH;
      S_FLUSH:  state_d = S_PD_RUN;
      S_PD_RUN: if (pd_cnt_q == PD_LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    pd_en      = (state_q == S_PD_RUN);
    frame_done = (state_q == S_DONE);
    rd_addr    = in_accum ? {cur_bin, cur_point} : '0;
    wr_addr    = wr_addr_q;
    err        = err_q;
  end

  always_comb begin
    bin_d        = bin_q;
    point_d      = point_q;
    pulse_cnt_d  = pulse_cnt_q;
    acc_pulses_d = acc_pulses_q;
    in_pulse_d   = in_pulse_q;
    wr_addr_d    = wr_addr_q;
    pd_cnt_d     = (state_q == S_PD_RUN) ? pd_cnt_q + PD_W'(1) : '0;
    if (start_ok) begin
      bin_d        = '0;
      point_d      = '0;
      pulse_cnt_d  = '0;
      in_pulse_d   = 1'b0;
      acc_pulses_d = acc_pulses;
    end
    if (accept) begin
      wr_addr_d = {cur_bin, cur_point};
      if (pulse_end) begin
        // hold the address until the next start-of-pulse realigns it
        bin_d       = cur_bin;
        point_d     = cur_point;
        in_pulse_d  = 1'b0;
        pulse_cnt_d = pulse_cnt_inc;
      end else begin
        in_pulse_d = 1'b1;
        if (cur_point == PT_LAST) begin
          point_d = '0;
          bin_d   = cur_bin + BIN_W'(1);
        end else begin
          point_d = cur_point + PT_W'(1);
          bin_d   = cur_bin;
        end
      end
    end
    err_d = err_q | drop_err | realign | ovf;
    if (start_ok) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q        <= '0;
      point_q      <= '0;
      pulse_cnt_q  <= '0;
      acc_pulses_q <= '0;
      in_pulse_q   <= 1'b0;
      err_q        <= 1'b0;
      pd_cnt_q     <= '0;
      wr_addr_q    <= '0;
    end else begin
      bin_q        <= bin_d;
      point_q      <= point_d;
      pulse_cnt_q  <= pulse_cnt_d;
      acc_pulses_q <= acc_pulses_d;
      in_pulse_q   <= in_pulse_d;
      err_q        <= err_d;
      pd_cnt_q     <= pd_cnt_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  sat_add32 u_sat_add32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_first  (pulse_cnt_q == '0),
    .in_din    (din),
    .acc_in    (rd_data),
    .out_valid (wr_en),
    .sum       (wr_data),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_spectrum_acc_writer.sv
// Scoreboard bench: stimulus pushes expected buffer writes, a negedge
// monitor pops and compares them against the DUT write port.
module tb_spectrum_acc_writer;

  localparam int RIP = 1024;
  localparam int TRB = 9;
  localparam int NPT = RIP * TRB;
  localparam int PD  = 9240;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_start;
  logic [15:0] acc_pulses;
  logic        din_valid;
  logic        din_sop;
  logic [31:0] din;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        pd_en;
  logic        busy;
  logic        frame_done;
  logic        err;

  spectrum_acc_writer dut (
    .clk        (clk),
    .rst        (rst),
    .acc_start  (acc_start),
    .acc_pulses (acc_pulses),
    .din_valid  (din_valid),
    .din_sop    (din_sop),
    .din        (din),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pd_en      (pd_en),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // external buffer RAM, 1-cycle read latency
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         expq[$];
  wr_t         mon_e;
  logic [31:0] refm [0:16383];
  int          n_checks = 0;
  int          n_fail   = 0;

  bit m_busy, m_accum, m_in, m_err;
  int m_idx, m_pulse, m_target;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got write %0h=%0h required none",
                 wr_addr, wr_data);
      end else begin
        mon_e = expq.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(mon_e.a));
        check("wr_data", 64'(wr_data), 64'(mon_e.d));
      end
    end
  end

  // reference: linear sample index per pulse, saturating sum per cell
  task automatic drive(input bit v, input bit sop, input logic [31:0] d);
    logic [13:0] a;
    logic [32:0] s;
    logic [31:0] val;
    @(posedge clk);
    #2;
    acc_start = 1'b0;
    din_valid = v;
    din_sop   = sop;
    din       = d;
    if (v && m_accum) begin
      if (sop || m_in) begin
        if (sop) begin
          if (m_in) m_err = 1'b1;
          m_idx = 0;
        end
        a = {4'(m_idx / RIP), 10'(m_idx % RIP)};
        if (m_pulse == 0) begin
          val = d;
        end else begin
          s = {1'b0, refm[a]} + {1'b0, d};
          if (s > 33'hFFFF_FFFF) begin
            val   = 32'hFFFF_FFFF;
            m_err = 1'b1;
          end else begin
            val = s[31:0];
          end
        end
        refm[a] = val;
        expq.push_back('{a: a, d: val});
        #1;
        check("rd_addr", 64'(rd_addr), 64'(a));
        m_idx++;
        if (m_idx == NPT) begin
          m_in = 1'b0;
          m_pulse++;
          if (m_pulse == m_target) m_accum = 1'b0;
        end else begin
          m_in = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic sample(input bit sop, input logic [31:0] d);
    if ($urandom_range(15) == 0) drive(1'b0, 1'b0, $urandom);
    drive(1'b1, sop, d);
  endtask

  task automatic start_frame(input logic [15:0] p);
    @(posedge clk);
    #2;
    acc_start  = 1'b1;
    acc_pulses = p;
    din_valid  = 1'b0;
    din_sop    = 1'b0;
    if (!m_busy && p != 0) begin
      m_busy   = 1'b1;
      m_accum  = 1'b1;
      m_in     = 1'b0;
      m_err    = 1'b0;
      m_pulse  = 0;
      m_target = p;
    end
  endtask

  task automatic finish_frame();
    int pd_cnt = 0;
    int wr_pd  = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < PD + 40 && !seen; i++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
      if (pd_en) pd_cnt++;
      if (pd_en && wr_en) wr_pd++;
      if (frame_done) seen = 1'b1;
    end
    m_busy = 1'b0;
    check("frame_done_seen", 64'(seen), 64'd1);
    check("pd_en_cycles", 64'(pd_cnt), 64'(PD));
    check("wr_en_in_pd", 64'(wr_pd), 64'd0);
    check("err_at_done", 64'(err), 64'(m_err));
    drive(1'b0, 1'b0, 32'h0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("q_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_pd_en"}, 64'(pd_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    acc_start  = 1'b0;
    acc_pulses = 16'd0;
    din_valid  = 1'b0;
    din_sop    = 1'b0;
    din        = 32'h0;
    m_busy = 1'b0; m_accum = 1'b0; m_in = 1'b0; m_err = 1'b0;
    m_idx = 0; m_pulse = 0; m_target = 0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    // zero pulse count is ignored
    start_frame(16'd0);
    drive(1'b0, 1'b0, 32'h0);
    check("busy_zero_pulses", 64'(busy), 64'd0);

    // stray sample, partial pulse, then reset mid-ACCUM
    start_frame(16'd1);
    drive(1'b0, 1'b0, 32'h0);
    check("busy_start", 64'(busy), 64'd1);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b0, 1'b0, 32'h0);
    check("err_stray", 64'(err), 64'd1);
    for (int i = 0; i < 300; i++) sample(i == 0, $urandom);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    check_all_zero("rst_mid");
    expq.delete();
    m_busy = 1'b0; m_accum = 1'b0; m_in = 1'b0; m_err = 1'b0;
    #5;
    rst = 1'b0;

    // frame A: one pulse, din = point index, ignored second start
    start_frame(16'd1);
    for (int i = 0; i < NPT; i++) begin
      if (i == 5000) begin
        start_frame(16'd2);
        drive(1'b0, 1'b0, 32'h0);
        check("busy_2nd_start", 64'(busy), 64'd1);
      end
      sample(i == 0, 32'(i % RIP));
    end
    finish_frame();

    // frame B: two pulses, saturation at address 0
    start_frame(16'd2);
    for (int i = 0; i < NPT; i++)
      sample(i == 0, (i == 0) ? 32'hFFFF_FFF0 : $urandom);
    drive(1'b0, 1'b0, 32'h0);
    check("err_before_ovf", 64'(err), 64'd0);
    sample(1'b1, 32'h20);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    check("err_ovf", 64'(err), 64'd1);
    for (int i = 1; i < NPT; i++) sample(1'b0, $urandom);
    finish_frame();

    // frame C: err cleared by start, sop abort at bin 2 point 100
    start_frame(16'd1);
    drive(1'b0, 1'b0, 32'h0);
    check("err_cleared", 64'(err), 64'd0);
    for (int i = 0; i < 2 * RIP + 100; i++) sample(i == 0, $urandom);
    drive(1'b0, 1'b0, 32'h0);
    check("err_pre_abort", 64'(err), 64'd0);
    drive(1'b1, 1'b1, $urandom);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    check("err_abort", 64'(err), 64'd1);
    for (int i = 1; i < NPT; i++) sample(1'b0, $urandom);
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
